// File: rtl/symm_sqrt1_if.sv
// symm_sqrt1_if: start/operand/result bundle for the element-wise 4x4 Q13 square root.
interface symm_sqrt1_if;
    logic start_sqrt1;
    logic signed [25:0] w11, w12, w13, w14, w21, w22, w23, w24;
    logic signed [25:0] w31, w32, w33, w34, w41, w42, w43, w44;
    logic signed [25:0] s11, s12, s13, s14, s21, s22, s23, s24;
    logic signed [25:0] s31, s32, s33, s34, s41, s42, s43, s44;
    logic [15:0] neg_sqrt1;
    logic busy_sqrt1, done_sqrt1;
    modport master (
        output start_sqrt1,
        output w11, w12, w13, w14, w21, w22, w23, w24,
        output w31, w32, w33, w34, w41, w42, w43, w44,
        input s11, s12, s13, s14, s21, s22, s23, s24,
        input s31, s32, s33, s34, s41, s42, s43, s44,
        input neg_sqrt1, busy_sqrt1, done_sqrt1
    );
    modport slave (
        input start_sqrt1,
        input w11, w12, w13, w14, w21, w22, w23, w24,
        input w31, w32, w33, w34, w41, w42, w43, w44,
        output s11, s12, s13, s14, s21, s22, s23, s24,
        output s31, s32, s33, s34, s41, s42, s43, s44,
        output neg_sqrt1, busy_sqrt1, done_sqrt1
    );
endinterface

// File: rtl/symm_sqrt1.sv
// symm_sqrt1: serial restoring square root of 16 Q13 elements, results published atomically.
// Define SYMM_SQRT1_ROUND_EN to round the root to nearest instead of truncating.
module symm_sqrt1 (
    input logic clk_sqrt1,
    input logic rst_sqrt1,
    symm_sqrt1_if.slave io
);
    typedef enum logic [2:0] {IDLE, LOAD, ITER, STORE, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [4:0] cnt_q, cnt_d;
    logic signed [25:0] w_a [16];
    logic signed [25:0] opnd_q [16], opnd_d [16];
    logic signed [25:0] res_q [16], res_d [16];
    logic signed [25:0] s_q [16], s_d [16];
    logic [39:0] rad_q, rad_d;
    logic [19:0] root_q, root_d;
    logic [22:0] rem_q, rem_d;
    logic [15:0] negm_q, negm_d, neg_q, neg_d;
    logic busy_q, busy_d, done_q, done_d;
    logic signed [25:0] x;
    logic [24:0] rem_sh, trial, diff;
    logic ge;
    logic [25:0] root_fin;
    logic unused_hi;

    assign w_a = '{io.w11, io.w12, io.w13, io.w14, io.w21, io.w22, io.w23, io.w24,
                   io.w31, io.w32, io.w33, io.w34, io.w41, io.w42, io.w43, io.w44};
    assign x = opnd_q[idx_q];
    // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
    assign rem_sh = {rem_q, rad_q[39:38]};
    assign trial = {3'd0, root_q, 2'b01};
    assign diff = rem_sh - trial;
    assign ge = rem_sh >= trial;
    assign unused_hi = ^{diff[24:23], rem_sh[24:23]};
`ifdef SYMM_SQRT1_ROUND_EN
    assign root_fin = {6'd0, root_q} + {25'd0, rem_q > {3'd0, root_q}};
`else
    assign root_fin = {6'd0, root_q};
`endif

    always_ff @(posedge clk_sqrt1 or posedge rst_sqrt1)
        if (rst_sqrt1) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = io.start_sqrt1 ? LOAD : IDLE;
            LOAD: state_d = ITER;
            ITER: state_d = cnt_q == 5'd19 ? STORE : ITER;
            STORE: state_d = idx_q == 4'd15 ? DONE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        opnd_d = opnd_q;
        res_d = res_q;
        s_d = s_q;
        rad_d = rad_q;
        root_d = root_q;
        rem_d = rem_q;
        negm_d = negm_q;
        neg_d = neg_q;
        busy_d = state_q == IDLE ? io.start_sqrt1 : state_q != DONE;
        done_d = state_q == DONE;
        unique case (state_q)
            IDLE: if (io.start_sqrt1) begin
                opnd_d = w_a;
                idx_d = 4'd0;
                negm_d = 16'd0;
            end
            LOAD: begin
                negm_d[idx_q] = x[25];
                rad_d = x[25] ? 40'd0 : {2'b00, x[24:0], 13'd0};
                root_d = 20'd0;
                rem_d = 23'd0;
                cnt_d = 5'd0;
            end
            ITER: begin
                rad_d = {rad_q[37:0], 2'b00};
                root_d = {root_q[18:0], ge};
                rem_d = ge ? diff[22:0] : rem_sh[22:0];
                cnt_d = cnt_q + 5'd1;
            end
            STORE: begin
                res_d[idx_q] = root_fin;
                idx_d = idx_q + 4'd1;
            end
            default: begin
                s_d = res_q;
                neg_d = negm_q;
            end
        endcase
    end

    always_ff @(posedge clk_sqrt1 or posedge rst_sqrt1)
        if (rst_sqrt1) begin
            idx_q <= '0;
            cnt_q <= '0;
            opnd_q <= '{default: '0};
            res_q <= '{default: '0};
            s_q <= '{default: '0};
            rad_q <= '0;
            root_q <= '0;
            rem_q <= '0;
            negm_q <= '0;
            neg_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            opnd_q <= opnd_d;
            res_q <= res_d;
            s_q <= s_d;
            rad_q <= rad_d;
            root_q <= root_d;
            rem_q <= rem_d;
            negm_q <= negm_d;
            neg_q <= neg_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end

    assign io.s11 = s_q[0];
    assign io.s12 = s_q[1];
    assign io.s13 = s_q[2];
    assign io.s14 = s_q[3];
    assign io.s21 = s_q[4];
    assign io.s22 = s_q[5];
    assign io.s23 = s_q[6];
    assign io.s24 = s_q[7];
    assign io.s31 = s_q[8];
    assign io.s32 = s_q[9];
    assign io.s33 = s_q[10];
    assign io.s34 = s_q[11];
    assign io.s41 = s_q[12];
    assign io.s42 = s_q[13];
    assign io.s43 = s_q[14];
    assign io.s44 = s_q[15];
    assign io.neg_sqrt1 = neg_q;
    assign io.busy_sqrt1 = busy_q;
    assign io.done_sqrt1 = done_q;
endmodule

// File: tb/tb_symm_sqrt1.sv
// tb_symm_sqrt1: directed vector table for symm_sqrt1 plus reset, re-start and back-to-back sequences.
module tb_symm_sqrt1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    symm_sqrt1_if intf();
    symm_sqrt1 dut (.clk_sqrt1(clk), .rst_sqrt1(rst), .io(intf));

    logic signed [25:0] w_a [16];
    logic signed [25:0] s_a [16];
    assign {intf.w11, intf.w12, intf.w13, intf.w14, intf.w21, intf.w22, intf.w23, intf.w24,
            intf.w31, intf.w32, intf.w33, intf.w34, intf.w41, intf.w42, intf.w43, intf.w44} =
           {w_a[0], w_a[1], w_a[2], w_a[3], w_a[4], w_a[5], w_a[6], w_a[7],
            w_a[8], w_a[9], w_a[10], w_a[11], w_a[12], w_a[13], w_a[14], w_a[15]};
    assign s_a = '{intf.s11, intf.s12, intf.s13, intf.s14, intf.s21, intf.s22, intf.s23, intf.s24,
                   intf.s31, intf.s32, intf.s33, intf.s34, intf.s41, intf.s42, intf.s43, intf.s44};

    typedef struct {
        logic signed [25:0] w [16];
        logic signed [25:0] e [16];
        logic [15:0] neg;
    } vec_t;
    vec_t tv [5];

`ifdef SYMM_SQRT1_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(input bit poke, output int lat, output int bn);
        lat = 0;
        bn = 0;
        while (!intf.done_sqrt1 && lat < 1000) begin
            if (intf.busy_sqrt1) bn++;
            intf.start_sqrt1 = poke && (lat == 4 || lat == 199);
            @(negedge clk);
            lat++;
        end
        intf.start_sqrt1 = 1'b0;
    endtask

    task automatic check_vec(input int v);
        for (int i = 0; i < 16; i++)
            chk($sformatf("v%0d_s[%0d]", v, i), s_a[i], tv[v].e[i]);
        chk($sformatf("v%0d_neg", v), intf.neg_sqrt1, tv[v].neg);
    endtask

    initial begin
        int lat, bn;
        bit chained;
        intf.start_sqrt1 = 1'b0;
        w_a = '{default: '0};
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 16; i++) begin
                tv[v].w[i] = 26'sd8192;
                tv[v].e[i] = 26'sd8192;
            end
            tv[v].neg = 16'h0000;
        end
        tv[1].w[0] = 32768;  tv[1].e[0] = 16384;
        tv[1].w[1] = 16384;  tv[1].e[1] = 11585;
        tv[1].w[2] = 4096;   tv[1].e[2] = 26'(5792 + RND);
        tv[1].w[3] = 0;      tv[1].e[3] = 0;
        tv[2].w[15] = 33554431; tv[2].e[15] = 26'(524287 + RND);
        tv[3].w[4] = -8192;  tv[3].e[4] = 0;
        tv[3].w[10] = -1;    tv[3].e[10] = 0;
        tv[3].neg = 16'h0410;
        tv[4].w[0] = 1;      tv[4].e[0] = 26'(90 + RND);
        tv[4].w[1] = 2;      tv[4].e[1] = 128;
        tv[4].w[2] = 100;    tv[4].e[2] = 905;
        tv[4].w[3] = 3;      tv[4].e[3] = 26'(156 + RND);
        tv[4].w[5] = -33554432; tv[4].e[5] = 0;
        tv[4].neg = 16'h0020;

        repeat (2) @(negedge clk);
        chk("rst_s11", s_a[0], 0);
        chk("rst_s44", s_a[15], 0);
        chk("rst_neg", intf.neg_sqrt1, 0);
        chk("rst_busy", intf.busy_sqrt1, 0);
        chk("rst_done", intf.done_sqrt1, 0);
        rst = 1'b0;

        // Vector 1 gets extra start pulses while busy; vector 3 is launched in vector 2's done cycle.
        chained = 1'b0;
        for (int v = 0; v < 5; v++) begin
            if (!chained) begin
                @(negedge clk);
                chk($sformatf("v%0d_idle_busy", v), intf.busy_sqrt1, 0);
                w_a = tv[v].w;
                intf.start_sqrt1 = 1'b1;
            end
            @(negedge clk);
            intf.start_sqrt1 = 1'b0;
            chk($sformatf("v%0d_done_low", v), intf.done_sqrt1, 0);
            chk($sformatf("v%0d_busy_high", v), intf.busy_sqrt1, 1);
            wait_done(v == 1, lat, bn);
            chk($sformatf("v%0d_latency", v), lat, 353);
            chk($sformatf("v%0d_busy_cycles", v), bn, 353);
            check_vec(v);
            chk($sformatf("v%0d_busy_at_done", v), intf.busy_sqrt1, 0);
            chained = v == 2;
            if (chained) begin
                w_a = tv[v + 1].w;
                intf.start_sqrt1 = 1'b1;
            end
        end

        @(negedge clk);
        w_a = tv[0].w;
        intf.start_sqrt1 = 1'b1;
        @(negedge clk);
        intf.start_sqrt1 = 1'b0;
        w_a = tv[2].w;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_s11", s_a[0], 0);
        chk("mid_rst_s12", s_a[1], 0);
        chk("mid_rst_neg", intf.neg_sqrt1, 0);
        chk("mid_rst_busy", intf.busy_sqrt1, 0);
        chk("mid_rst_done", intf.done_sqrt1, 0);
        @(negedge clk);
        rst = 1'b0;
        bn = 0;
        repeat (400) begin
            @(negedge clk);
            if (intf.done_sqrt1 || intf.busy_sqrt1) bn++;
        end
        chk("post_rst_quiet", bn, 0);

        @(negedge clk);
        w_a = tv[3].w;
        intf.start_sqrt1 = 1'b1;
        @(negedge clk);
        intf.start_sqrt1 = 1'b0;
        w_a = tv[1].w;
        wait_done(1'b0, lat, bn);
        chk("post_rst_latency", lat, 353);
        check_vec(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
